// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit memory path.
//   mem_width_t : 2-bit access width (byte / half / word)
//   arb_state_t : memory port arbiter FSM states
//   issue_t     : one memory transaction as presented on the port
package load_store_unit_pkg;

  typedef logic [1:0] mem_width_t;

  localparam mem_width_t WIDTH_BYTE = 2'b00;
  localparam mem_width_t WIDTH_HALF = 2'b01;
  localparam mem_width_t WIDTH_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] data;
    mem_width_t  width;
    logic        write;
  } issue_t;

endpackage

// File: rtl/memory_port_grant_logic.sv
// Two-way priority picker for the shared data-memory port. Purely
// combinational; the caller gates the candidates so that a grant can only
// be produced while the port is free.
//   ld_cand_i       : a load is available (slot or same-cycle pulse)
//   st_cand_i       : a store is available (slot or same-cycle pulse)
//   str_buf_full_i  : store buffer full, store takes the port
//   starve_count_i  : loads granted in a row over a waiting store
//   grant_ld_o      : load wins this cycle
//   grant_st_o      : store wins this cycle
module memory_port_grant_logic #(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                ld_cand_i,
  input  logic                st_cand_i,
  input  logic                str_buf_full_i,
  input  logic [STARVE_W-1:0] starve_count_i,
  output logic                grant_ld_o,
  output logic                grant_st_o
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch.
    grant_ld_o = 1'b0;
    grant_st_o = 1'b0;
    if (ld_cand_i && st_cand_i) begin
      // Loads normally win; a full store buffer or a starved store overrides.
      if (str_buf_full_i || (starve_count_i == STARVE_MAX)) begin
        grant_st_o = 1'b1;
      end else begin
        grant_ld_o = 1'b1;
      end
    end else begin
      grant_ld_o = ld_cand_i;
      grant_st_o = st_cand_i;
    end
  end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares the single data-memory port between the load unit and the store
// unit. Request pulses are latched into one slot per requester, arbitrated
// in IDLE (load priority, store anti-starvation), issued through a
// registered request/ready/valid handshake and answered to their owner.
// A watchdog aborts a transaction that stays in ISSUE+WAIT too long.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   ld_request_i/address_i  : load request pulse and address
//   ld_data_o, ld_valid_o   : load response (data is 0 unless valid)
//   st_request_i/address_i/data_i/width_i : store request pulse and payload
//   st_done_o               : store completion pulse
//   str_buf_full_i          : store buffer full, store wins arbitration
//   mem_*_o / mem_*_i       : memory port handshake
//   bus_error_o             : watchdog abort pulse
//   idle_o                  : nothing pending, in flight or arriving
module memory_port_arbiter
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ld_request_i,
  input  logic [31:0] ld_address_i,
  output logic [31:0] ld_data_o,
  output logic        ld_valid_o,
  input  logic        st_request_i,
  input  logic [31:0] st_address_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  st_width_i,
  output logic        st_done_o,
  input  logic        str_buf_full_i,
  output logic        mem_request_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic [1:0]  mem_width_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i,
  output logic        bus_error_o,
  output logic        idle_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam int               STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state_q;
  issue_t              issue_q;
  logic                mem_request_q;
  logic                ld_pend_q;
  logic [31:0]         ld_addr_q;
  logic                st_pend_q;
  issue_t              st_slot_q;
  logic [STARVE_W-1:0] starve_q;
  logic [TMO_W-1:0]    tmo_q;

  logic   in_idle, ld_busy, st_busy;
  logic   ld_accept, st_accept, ld_cand, st_cand;
  logic   grant_ld, grant_st;
  logic   complete, timeout, finish;
  issue_t ld_issue, st_issue, st_incoming;

  assign in_idle = (state_q == ARB_IDLE);
  assign ld_busy = !in_idle && !issue_q.write;
  assign st_busy = !in_idle &&  issue_q.write;

  // A pulse is taken only into a free slot whose type is not on the port;
  // anything else is a protocol violation and the original is kept.
  assign ld_accept = ld_request_i && !ld_pend_q && !ld_busy;
  assign st_accept = st_request_i && !st_pend_q && !st_busy;

  // Candidates include same-cycle pulses so a fresh request loses no cycle.
  assign ld_cand = in_idle && (ld_pend_q || ld_accept);
  assign st_cand = in_idle && (st_pend_q || st_accept);

  assign st_incoming = '{address: st_address_i, data: st_data_i,
                         width: st_width_i, write: 1'b1};
  assign st_issue    = st_pend_q ? st_slot_q : st_incoming;
  assign ld_issue    = '{address: (ld_pend_q ? ld_addr_q : ld_address_i),
                         data: '0, width: WIDTH_WORD, write: 1'b0};

  memory_port_grant_logic #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_grant (
    .ld_cand_i      (ld_cand),
    .st_cand_i      (st_cand),
    .str_buf_full_i (str_buf_full_i),
    .starve_count_i (starve_q),
    .grant_ld_o     (grant_ld),
    .grant_st_o     (grant_st)
  );

  // A real response in the last watchdog cycle wins over the abort.
  assign complete = (state_q == ARB_WAIT) && mem_valid_i;
  assign timeout  = !in_idle && (tmo_q == TMO_LAST) && !complete;
  assign finish   = complete || timeout;

  assign ld_valid_o  = finish && !issue_q.write;
  assign st_done_o   = finish &&  issue_q.write;
  assign ld_data_o   = (complete && !issue_q.write) ? mem_data_i : '0;
  assign bus_error_o = timeout;
  assign idle_o      = in_idle && !ld_pend_q && !st_pend_q
                       && !ld_request_i && !st_request_i;

  assign mem_request_o = mem_request_q;
  assign mem_write_o   = issue_q.write;
  assign mem_address_o = issue_q.address;
  assign mem_data_o    = issue_q.data;
  assign mem_width_o   = issue_q.width;

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q       <= ARB_IDLE;
      issue_q       <= '0;
      mem_request_q <= 1'b0;
      ld_pend_q     <= 1'b0;
      st_pend_q     <= 1'b0;
      starve_q      <= '0;
      tmo_q         <= '0;
    end else begin
      if (grant_ld)       ld_pend_q <= 1'b0;
      else if (ld_accept) ld_pend_q <= 1'b1;

      if (grant_st)       st_pend_q <= 1'b0;
      else if (st_accept) st_pend_q <= 1'b1;

      if (grant_st)                starve_q <= '0;
      else if (grant_ld && st_cand) starve_q <= starve_q + 1'b1;

      case (state_q)
        ARB_IDLE: begin
          if (grant_ld || grant_st) begin
            issue_q       <= grant_st ? st_issue : ld_issue;
            mem_request_q <= 1'b1;
            tmo_q         <= '0;
            state_q       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (timeout) begin
            mem_request_q <= 1'b0;
            state_q       <= ARB_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (mem_ready_i) begin
              mem_request_q <= 1'b0;
              state_q       <= ARB_WAIT;
            end
          end
        end
        ARB_WAIT: begin
          if (finish) state_q <= ARB_IDLE;
          else        tmo_q   <= tmo_q + 1'b1;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // NOTE: slot payloads carry no reset; the pending flags decide whether
  // they are ever read, so reset only has to clear the flags.
  always_ff @(posedge clk_i) begin
    if (ld_accept && !grant_ld) ld_addr_q <= ld_address_i;
    if (st_accept && !grant_st) st_slot_q <= st_incoming;
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
module tb_memory_port_arbiter;
  import load_store_unit_pkg::*;

  localparam int TMO    = 8;
  localparam int STARVE = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ld_request_i;
  logic [31:0] ld_address_i;
  logic [31:0] ld_data_o;
  logic        ld_valid_o;
  logic        st_request_i;
  logic [31:0] st_address_i;
  logic [31:0] st_data_i;
  logic [1:0]  st_width_i;
  logic        st_done_o;
  logic        str_buf_full_i;
  logic        mem_request_o;
  logic        mem_write_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_data_o;
  logic [1:0]  mem_width_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic        mem_valid_i;
  logic        bus_error_o;
  logic        idle_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  memory_port_arbiter #(
    .TIMEOUT_CYCLES (TMO),
    .STARVE_LIMIT   (STARVE)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ld_request_i   (ld_request_i),
    .ld_address_i   (ld_address_i),
    .ld_data_o      (ld_data_o),
    .ld_valid_o     (ld_valid_o),
    .st_request_i   (st_request_i),
    .st_address_i   (st_address_i),
    .st_data_i      (st_data_i),
    .st_width_i     (st_width_i),
    .st_done_o      (st_done_o),
    .str_buf_full_i (str_buf_full_i),
    .mem_request_o  (mem_request_o),
    .mem_write_o    (mem_write_o),
    .mem_address_o  (mem_address_o),
    .mem_data_o     (mem_data_o),
    .mem_width_o    (mem_width_o),
    .mem_ready_i    (mem_ready_i),
    .mem_data_i     (mem_data_i),
    .mem_valid_i    (mem_valid_i),
    .bus_error_o    (bus_error_o),
    .idle_o         (idle_o)
  );

  task automatic idle_inputs();
    ld_request_i = 1'b0; ld_address_i = '0;
    st_request_i = 1'b0; st_address_i = '0; st_data_i = '0; st_width_i = '0;
    str_buf_full_i = 1'b0;
    mem_ready_i = 1'b0; mem_valid_i = 1'b0; mem_data_i = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read at
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst_i = 1'b0;
  endtask

  // Memory-side responder: waits (bounded) for a request, accepts it in the
  // cycle it is seen, returns valid the next cycle and records the response.
  task automatic serve_one(input logic [31:0] rdata, output bit seen,
                           output issue_t txn, output bit got_ld,
                           output bit got_st, output bit got_err,
                           output logic [31:0] got_data);
    seen = 1'b0; txn = '0; got_ld = 1'b0; got_st = 1'b0; got_err = 1'b0;
    got_data = '0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_request_o) begin
        seen = 1'b1;
        txn  = '{address: mem_address_o, data: mem_data_o,
                 width: mem_width_o, write: mem_write_o};
      end else begin
        next_cycle();
      end
    end
    if (!seen) return;
    mem_ready_i = 1'b1;
    next_cycle();
    mem_ready_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = rdata;
    @(negedge clk_i);
    got_ld = ld_valid_o; got_st = st_done_o; got_err = bus_error_o;
    got_data = ld_data_o;
    next_cycle();
    mem_valid_i = 1'b0; mem_data_i = '0;
  endtask

  task automatic test_reset();
    logic [101:0] got, exp;
    apply_reset();
    @(negedge clk_i);
    got = {mem_request_o, mem_write_o, mem_address_o, mem_data_o, mem_width_o,
           ld_valid_o, st_done_o, bus_error_o, idle_o};
    exp = {1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", got, exp);
    end
    n_cmp++;
    if (ld_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_ld_data: got %h expected 0", ld_data_o);
    end
    next_cycle();
  endtask

  task automatic test_single_load();
    issue_t txn, exp_txn;
    apply_reset();
    ld_request_i = 1'b1; ld_address_i = 32'h0000_1004;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_request_o, idle_o} !== 2'b00) begin
      n_fail++; $display("FAIL load_c0: got req/idle %b expected 00", {mem_request_o, idle_o});
    end
    next_cycle();
    ld_request_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk_i);
    txn = '{address: mem_address_o, data: mem_data_o, width: mem_width_o, write: mem_write_o};
    exp_txn = '{address: 32'h0000_1004, data: 32'h0, width: WIDTH_WORD, write: 1'b0};
    n_cmp++;
    if ({mem_request_o, txn} !== {1'b1, exp_txn}) begin
      n_fail++; $display("FAIL load_c1_issue: got %h expected %h", {mem_request_o, txn}, {1'b1, exp_txn});
    end
    next_cycle();
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_request_o, ld_valid_o} !== 2'b00) begin
      n_fail++; $display("FAIL load_c2: got req/valid %b expected 00", {mem_request_o, ld_valid_o});
    end
    next_cycle();
    mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    n_cmp++;
    if ({ld_valid_o, st_done_o, bus_error_o, ld_data_o} !== {3'b100, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL load_c3_resp: got %b/%h expected 100/deadbeef",
                         {ld_valid_o, st_done_o, bus_error_o}, ld_data_o);
    end
    next_cycle();
    mem_valid_i = 1'b0; mem_data_i = '0;
    @(negedge clk_i);
    n_cmp++;
    if ({ld_valid_o, idle_o, ld_data_o} !== {2'b01, 32'h0}) begin
      n_fail++; $display("FAIL load_c4_idle: got valid/idle %b data %h expected 01/0",
                         {ld_valid_o, idle_o}, ld_data_o);
    end
    next_cycle();
  endtask

  task automatic test_collision(input bit buf_full);
    issue_t ld_txn, st_txn, txn, exp_txn;
    bit seen, g_ld, g_st, g_err;
    logic [31:0] g_data, rdata;
    ld_txn = '{address: 32'h100, data: 32'h0, width: WIDTH_WORD, write: 1'b0};
    st_txn = '{address: 32'h200, data: 32'hA5A5_A5A5, width: WIDTH_BYTE, write: 1'b1};
    apply_reset();
    ld_request_i = 1'b1; ld_address_i = 32'h100;
    st_request_i = 1'b1; st_address_i = 32'h200; st_data_i = 32'hA5A5_A5A5;
    st_width_i = 2'b00; str_buf_full_i = buf_full;
    next_cycle();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      rdata = $urandom;
      serve_one(rdata, seen, txn, g_ld, g_st, g_err, g_data);
      exp_txn = ((k == 0) == buf_full) ? st_txn : ld_txn;
      n_cmp++;
      if ({seen, txn} !== {1'b1, exp_txn}) begin
        n_fail++; $display("FAIL collision%0d_txn%0d: got %h expected %h",
                           buf_full, k, {seen, txn}, {1'b1, exp_txn});
      end
      n_cmp++;
      if ({g_ld, g_st, g_err, g_data} !==
          {~exp_txn.write, exp_txn.write, 1'b0, (exp_txn.write ? 32'h0 : rdata)}) begin
        n_fail++; $display("FAIL collision%0d_resp%0d: got %b/%h expected write=%b data %h",
                           buf_full, k, {g_ld, g_st, g_err}, g_data, exp_txn.write, rdata);
      end
    end
    @(negedge clk_i);
    n_cmp++;
    if (idle_o !== 1'b1) begin
      n_fail++; $display("FAIL collision%0d_idle: got %b expected 1", buf_full, idle_o);
    end
    next_cycle();
  endtask

  // Store held while loads keep arriving: four loads pass it, then it is
  // forced. Two rounds show the starve count restarts after the store.
  task automatic test_starvation();
    issue_t txn;
    bit seen, g_ld, g_st, g_err;
    logic [31:0] g_data;
    logic [6:0] order, seen_all;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      order = '0; seen_all = '0;
      ld_request_i = 1'b1; ld_address_i = 32'h4000 + 32'(r);
      next_cycle();
      ld_request_i = 1'b0;
      st_request_i = 1'b1; st_address_i = 32'h8000 + 32'(r); st_data_i = $urandom;
      st_width_i = 2'b01;
      next_cycle();
      st_request_i = 1'b0;
      for (int k = 0; k < 7; k++) begin
        serve_one($urandom, seen, txn, g_ld, g_st, g_err, g_data);
        seen_all[k] = seen;
        order[k] = txn.write;
        if (k < 5) begin
          ld_request_i = 1'b1; ld_address_i = 32'h5000 + 32'(k);
          next_cycle();
          ld_request_i = 1'b0;
        end
      end
      n_cmp++;
      if ({seen_all, order} !== {7'h7F, 7'b010_0000}) begin
        n_fail++; $display("FAIL starvation_round%0d: got seen %b order %b expected 1111111/0100000",
                           r, seen_all, order);
      end
    end
  endtask

  // s0: load, accepted, no data; s1: store never accepted;
  // s2: load whose data arrives in the last watchdog cycle.
  task automatic test_timeout();
    logic [4:0]  got, exp;
    logic [31:0] exp_data;
    for (int s = 0; s < 3; s++) begin
      apply_reset();
      mem_data_i = 32'hCAFE_F00D;
      if (s == 1) begin
        st_request_i = 1'b1; st_address_i = 32'h700; st_data_i = 32'h1;
      end else begin
        ld_request_i = 1'b1; ld_address_i = 32'h300;
      end
      next_cycle();
      ld_request_i = 1'b0; st_request_i = 1'b0;
      for (int k = 1; k <= TMO + 1; k++) begin
        mem_ready_i = (s == 0) || (s == 2 && k == 1);
        mem_valid_i = (s == 2 && k == TMO);
        @(negedge clk_i);
        got = {mem_request_o, ld_valid_o, st_done_o, bus_error_o, idle_o};
        exp = {((s == 1) ? (k <= TMO) : (k == 1)),
               (k == TMO) && (s != 1), (k == TMO) && (s == 1),
               (k == TMO) && (s != 2), (k == TMO + 1)};
        exp_data = (s == 2 && k == TMO) ? 32'hCAFE_F00D : 32'h0;
        n_cmp++;
        if ({got, ld_data_o} !== {exp, exp_data}) begin
          n_fail++; $display("FAIL timeout_s%0d_k%0d: got %b/%h expected %b/%h",
                             s, k, got, ld_data_o, exp, exp_data);
        end
        next_cycle();
      end
      idle_inputs();
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    ld_request_i = 1'b1; ld_address_i = 32'h800;
    next_cycle();
    ld_request_i = 1'b0; mem_ready_i = 1'b1;
    next_cycle();
    mem_ready_i = 1'b0;
    st_request_i = 1'b1; st_address_i = 32'h900; st_data_i = 32'h55;
    next_cycle();
    st_request_i = 1'b0; rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'h1234_5678;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_request_o, ld_valid_o, st_done_o, bus_error_o, idle_o, ld_data_o} !==
        {5'b00001, 32'h0}) begin
      n_fail++; $display("FAIL reset_wait_resp: got %b/%h expected 00001/0",
                         {mem_request_o, ld_valid_o, st_done_o, bus_error_o, idle_o}, ld_data_o);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_valid_i = 1'b0;
      @(negedge clk_i);
      n_cmp++;
      if ({mem_request_o, idle_o} !== 2'b01) begin
        n_fail++; $display("FAIL reset_wait_after%0d: got req/idle %b expected 01",
                           k, {mem_request_o, idle_o});
      end
    end
    next_cycle();
  endtask

  // Random traffic against a transaction-level model: one outstanding
  // transaction with an age, one waiting item per requester, and a count of
  // loads that overtook a waiting store.
  task automatic test_random(input int cycles);
    bit          busy = 0, accepted = 0, ld_slot = 0, st_slot = 0;
    bit          stall, completion, timeout, ld_new, st_new, take_store;
    int          age = 0, starve = 0;
    issue_t      cur = '0, st_held = '0, bus;
    logic [31:0] ld_held = '0, exp_data;
    logic [4:0]  got, exp;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      stall = ((c / 200) % 4) == 3;
      ld_request_i   = ($urandom_range(0, 99) < 25);
      ld_address_i   = $urandom;
      st_request_i   = ($urandom_range(0, 99) < 25);
      st_address_i   = $urandom;
      st_data_i      = $urandom;
      st_width_i     = 2'($urandom_range(0, 2));
      str_buf_full_i = ($urandom_range(0, 99) < 15);
      mem_ready_i    = ($urandom_range(0, 99) < (stall ? 5 : 60));
      mem_valid_i    = ($urandom_range(0, 99) < (stall ? 5 : 45));
      mem_data_i     = $urandom;
      @(negedge clk_i);
      completion = busy && accepted && mem_valid_i;
      timeout    = busy && (age == TMO - 1) && !completion;
      exp = {busy && !accepted,
             (completion || timeout) && !cur.write,
             (completion || timeout) && cur.write,
             timeout,
             !busy && !ld_slot && !st_slot && !ld_request_i && !st_request_i};
      got = {mem_request_o, ld_valid_o, st_done_o, bus_error_o, idle_o};
      n_cmp++;
      if (got !== exp) begin
        n_fail++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", c, got, exp);
      end
      exp_data = (completion && !cur.write) ? mem_data_i : 32'h0;
      n_cmp++;
      if (ld_data_o !== exp_data) begin
        n_fail++; $display("FAIL random_ld_data cycle %0d: got %h expected %h", c, ld_data_o, exp_data);
      end
      if (busy && !accepted) begin
        bus = '{address: mem_address_o, data: mem_data_o, width: mem_width_o, write: mem_write_o};
        n_cmp++;
        if (bus !== cur) begin
          n_fail++; $display("FAIL random_bus cycle %0d: got %h expected %h", c, bus, cur);
        end
      end
      // Model update for the coming clock edge.
      ld_new = ld_request_i && !ld_slot && !(busy && !cur.write);
      st_new = st_request_i && !st_slot && !(busy && cur.write);
      if (ld_new) begin ld_slot = 1; ld_held = ld_address_i; end
      if (st_new) begin
        st_slot = 1;
        st_held = '{address: st_address_i, data: st_data_i, width: st_width_i, write: 1'b1};
      end
      if (busy) begin
        if (completion || timeout) begin
          busy = 0;
        end else begin
          age++;
          if (!accepted && mem_ready_i) accepted = 1;
        end
      end else if (ld_slot || st_slot) begin
        take_store = st_slot && (!ld_slot || str_buf_full_i || starve == STARVE);
        if (take_store) begin
          cur = st_held; st_slot = 0; starve = 0;
        end else begin
          cur = '{address: ld_held, data: 32'h0, width: WIDTH_WORD, write: 1'b0};
          ld_slot = 0;
          if (st_slot) starve++;
        end
        busy = 1; accepted = 0; age = 0;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    test_reset();
    test_single_load();
    test_collision(1'b0);
    test_collision(1'b1);
    test_starvation();
    test_timeout();
    test_reset_mid_wait();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
